// File: rtl/mux_arb_nxw.sv
// N-channel, W-bit registered selector with valid/ready handshakes.
// MODE=0 picks the channel named by S; MODE=1 arbitrates round-robin over requesters.
//
// Handshake: an input word moves when IN_VALID[i] & IN_READY[i] at a rising edge;
// an output word moves when OUT_VALID & OUT_READY at a rising edge. IN_READY never
// depends on IN_DATA, and no output register sees a combinational input path.
module mux_arb_nxw #(
  parameter int W    = 32,
  parameter int N    = 4,
  parameter int MODE = 0,
  localparam int SW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic           CLK,
  input  logic           CLRN,
  input  logic [N*W-1:0] IN_DATA,
  input  logic [N-1:0]   IN_VALID,
  output logic [N-1:0]   IN_READY,
  input  logic [SW-1:0]  S,
  output logic [W-1:0]   OUT_DATA,
  output logic           OUT_VALID,
  input  logic           OUT_READY,
  output logic [SW-1:0]  OUT_SEL
);

  logic [W-1:0]  r_out_data;
  logic          r_out_valid;
  logic [SW-1:0] r_out_sel;
  logic [SW-1:0] r_last;

  logic          w_load;
  logic [N-1:0]  w_grant_dir;
  logic [SW-1:0] w_idx_dir;
  logic [N-1:0]  w_grant_rr;
  logic [SW-1:0] w_idx_rr;
  logic          w_rr_any;
  logic          w_found_hi;
  logic          w_found_lo;
  logic [SW-1:0] w_idx_hi;
  logic [SW-1:0] w_idx_lo;
  logic [N-1:0]  w_grant;
  logic [SW-1:0] w_idx;
  logic          w_any;
  logic [W-1:0]  w_gdata;

  assign w_load = ~r_out_valid | OUT_READY;

  // Directed select: an out-of-range S matches no channel and so never grants.
  always_comb begin
    w_grant_dir = '0;
    w_idx_dir   = '0;
    for (int i = 0; i < N; i++) begin
      if ((S == SW'(i)) && IN_VALID[i]) begin
        w_grant_dir[i] = 1'b1;
        w_idx_dir      = SW'(i);
      end
    end
  end

  // Circular search from last+1: lowest requester above last, else lowest at or below it.
  always_comb begin
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_idx_hi   = '0;
    w_idx_lo   = '0;
    w_idx_rr   = '0;
    w_rr_any   = 1'b0;
    w_grant_rr = '0;
    for (int i = 0; i < N; i++) begin
      if (!w_found_hi && IN_VALID[i] && (SW'(i) > r_last)) begin
        w_found_hi = 1'b1;
        w_idx_hi   = SW'(i);
      end
      if (!w_found_lo && IN_VALID[i] && (SW'(i) <= r_last)) begin
        w_found_lo = 1'b1;
        w_idx_lo   = SW'(i);
      end
    end
    if (w_found_hi) begin
      w_idx_rr = w_idx_hi;
      w_rr_any = 1'b1;
    end else if (w_found_lo) begin
      w_idx_rr = w_idx_lo;
      w_rr_any = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      w_grant_rr[i] = w_rr_any && (w_idx_rr == SW'(i));
    end
  end

  assign w_grant = (MODE == 1) ? w_grant_rr : w_grant_dir;
  assign w_idx   = (MODE == 1) ? w_idx_rr   : w_idx_dir;
  assign w_any   = |w_grant;

  always_comb begin
    w_gdata = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_gdata = IN_DATA[i*W +: W];
      end
    end
  end

  // CLRN gates IN_READY so nothing is offered while the register is held in reset.
  assign IN_READY = w_grant & {N{w_load & CLRN}};

  always_ff @(posedge CLK or negedge CLRN) begin
    if (!CLRN) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_sel   <= '0;
      r_last      <= SW'(N - 1);
    end else if (w_load) begin
      if (w_any) begin
        r_out_data  <= w_gdata;
        r_out_sel   <= w_idx;
        r_out_valid <= 1'b1;
        if (MODE == 1) begin
          r_last <= w_idx;
        end
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign OUT_DATA  = r_out_data;
  assign OUT_VALID = r_out_valid;
  assign OUT_SEL   = r_out_sel;

  a_ready_onehot: assert property (@(posedge CLK) disable iff (!CLRN)
    $onehot0(IN_READY));
  a_ready_needs_valid: assert property (@(posedge CLK) disable iff (!CLRN)
    ((IN_READY & ~IN_VALID) == '0));
  a_stall_hold: assert property (@(posedge CLK) disable iff (!CLRN)
    (OUT_VALID && !OUT_READY) |=> (OUT_VALID && $stable(OUT_DATA) && $stable(OUT_SEL)));
  a_sel_range: assert property (@(posedge CLK) disable iff (!CLRN)
    (int'(OUT_SEL) < N));

endmodule

// File: doc/mux_arb_nxw.md
# mux_arb_nxw

Parametrised N-channel, W-bit registered selector with valid/ready handshakes. It generalises the fixed four-way 32-bit datapath multiplexer in two ways: channel count and width are parameters, and an output register with backpressure is added. It also offers a round-robin arbitration mode. It sits between multiple requesters and one consumer, for example instruction/data ports sharing a memory port, or writeback sources feeding the register file in the pipelined core.

## Interface
- W, 32, data width per channel (≥1)
- N, 4, channel count (≥2, need not be a power of two)
- MODE, 0, 0 = directed select (S picks channel), 1 = round-robin arbitration (S ignored)
- SW, derived localparam = clog2(N), select/index width

- CLK  in  1  clock, rising edge
- CLRN  in  1  asynchronous active-low reset
- IN_DATA  in  N*W  channel i occupies bits [i*W +: W]
- IN_VALID  in  N  channel i presents data
- IN_READY  out  N  channel i data accepted this cycle
- S  in  SW  channel select, used only when MODE=0
- OUT_DATA  out  W  registered selected data
- OUT_VALID  out  1  OUT_DATA holds an untaken word
- OUT_READY  in  1  consumer takes word this cycle
- OUT_SEL  out  SW  index of channel that supplied OUT_DATA

## Operation
- A one-entry output register holds OUT_DATA, OUT_SEL and OUT_VALID.
- load = ~OUT_VALID | OUT_READY. The register may be refilled this cycle.
- Grant in MODE=0: channel S if S < N and IN_VALID[S]. Otherwise there is no grant. S ≥ N never grants.
- Grant in MODE=1: the first i with IN_VALID[i] set, searching circularly from (last+1) mod N, where `last` is the last granted index. At most one grant.
- IN_READY[i] = load & grant[i]. This is combinational and is never asserted for a channel with IN_VALID low.
- On a clock edge with load and a grant to channel g:
  - OUT_DATA ← IN_DATA[g]
  - OUT_SEL ← g
  - OUT_VALID ← 1
  - in MODE=1, last ← g
- On a clock edge with load and no grant: OUT_VALID ← 0. OUT_DATA and OUT_SEL hold their old values.
- On a clock edge without load (stalled): all registers hold and all IN_READY are 0.
- A simultaneous drain and refill (OUT_READY=1 with a grant) yields back-to-back words with no bubble.
- The round-robin pointer advances only on an accepted transfer, never on a stall.
- `last` wraps from N-1 to 0. For non-power-of-two N, indices ≥ N are never produced.
- Reset is asynchronous on CLRN low and takes effect immediately:
  - OUT_VALID = 0, OUT_DATA = 0, OUT_SEL = 0, last = N-1, so channel 0 has first priority.
  - A word held in the register mid-transfer is discarded.
  - IN_READY is 0 throughout reset.

## Timing
- Latency is 1 cycle from IN_VALID&IN_READY to OUT_VALID.
- Throughput is 1 word/cycle under continuous OUT_READY.
- While OUT_VALID=1 and OUT_READY=0, OUT_DATA and OUT_SEL are stable.
- IN_READY has combinational paths from OUT_READY, OUT_VALID, IN_VALID and S, plus `last` in MODE=1. No combinational path from any input to OUT_DATA, OUT_VALID or OUT_SEL.
- Upstream must hold IN_DATA stable while IN_VALID=1 and IN_READY=0. The block does not require IN_VALID to stay high.
- Release from reset is synchronised externally. The first grant can occur on the first rising edge with CLRN high.

## Test plan
- **MODE=0 directed select, N=4, W=32.** All IN_VALID=1, IN_DATA[i]=0x1000_0000+i, S=2, OUT_READY=1. Required: IN_READY=4'b0100. The next cycle gives OUT_DATA=0x1000_0002, OUT_SEL=2, OUT_VALID=1. Changing S to 3 gives 0x1000_0003 the following cycle with no bubble.
- **MODE=1 fairness, N=4.** All IN_VALID held 1 and OUT_READY=1 from reset. Required: OUT_SEL sequence 0,1,2,3,0,1,... with exactly one IN_READY high per cycle.
- **Backpressure.** A word is loaded, then OUT_READY=0 for 3 cycles with new IN_DATA applied. Required: OUT_DATA and OUT_SEL unchanged, IN_READY=0 on all channels, and the round-robin pointer unchanged. When OUT_READY returns to 1, the next grant follows the pre-stall pointer.
- **Sparse requests, MODE=1, N=3 (non-power-of-two).** IN_VALID=3'b101 continuously. Required: OUT_SEL alternates 0,2,0,2 and never reads 3. With IN_VALID=0, OUT_VALID falls one cycle after the last word drains.
- **Invalid select, MODE=0, N=3.** S=3 with all IN_VALID=1. Required: no IN_READY, and OUT_VALID=0 after the current word drains.
- **Mid-operation reset.** OUT_VALID=1 and OUT_READY=0, then CLRN pulsed low between clock edges. Required: OUT_VALID=0, OUT_DATA=0 and OUT_SEL=0 immediately without a clock edge. After release, MODE=1 grants channel 0 first.
